// File: rtl/thor2024_regfile_source_pkg.sv
// Thor2024 shared types for register source tracking.
package Thor2024pkg;

  localparam int TAG_W = 5;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [2:0]       que_ndx_t;
  typedef logic [5:0]       regspec_t;

  // Tag value meaning "no pending producer; the value lives in the register file".
  localparam tag_t TAG_NONE = 5'h1F;

  // Producer tag for a queue index.
  function automatic tag_t qtag(input que_ndx_t q);
    return {2'b00, q};
  endfunction

endpackage

// File: rtl/thor2024_regfile_source_youngest_producer.sv
// Combinational scan for one architectural register: the youngest surviving
// producer between head0 and missid (inclusive, wrapping), plus whether any
// valid queue entry targets the register at all.
module thor2024_youngest_producer
  import Thor2024pkg::*;
#(
  parameter int       QENTRIES = 8,
  parameter regspec_t REG      = '0
) (
  input  que_ndx_t                head0_i,
  input  que_ndx_t                missid_i,
  input  logic     [QENTRIES-1:0] iq_v_i,
  input  logic     [QENTRIES-1:0] iq_rfw_i,
  input  regspec_t [QENTRIES-1:0] iq_tgt_i,
  output logic                    surv_hit_o,
  output que_ndx_t                surv_idx_o,
  output logic                    any_hit_o
);

  que_ndx_t span;
  que_ndx_t idx;
  logic     match;

  // Walk from oldest to youngest; a later match within the survivor span overrides.
  always_comb begin
    span       = missid_i - head0_i;
    idx        = head0_i;
    match      = 1'b0;
    surv_hit_o = 1'b0;
    surv_idx_o = head0_i;
    any_hit_o  = 1'b0;
    for (int k = 0; k < QENTRIES; k++) begin
      idx   = head0_i + que_ndx_t'(k);
      match = iq_v_i[idx] && iq_rfw_i[idx] && (iq_tgt_i[idx] == REG);
      if (match && (que_ndx_t'(k) <= span)) begin
        surv_hit_o = 1'b1;
        surv_idx_o = idx;
      end
      if (match) begin
        any_hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/thor2024_regfile_source.sv
// Register source-tag table: per architectural register, which queue entry
// will produce its next value. Updated at enqueue and commit, rebuilt from
// surviving queue entries on a branch miss.
module thor2024_regfile_source
  import Thor2024pkg::*;
#(
  parameter int AREGS      = 64,
  parameter int QENTRIES   = 8,
  parameter int LR0        = 56,
  parameter int SUPPORT_Q2 = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    branchmiss,
  input  que_ndx_t                missid,
  input  que_ndx_t                head0,
  input  logic                    fetchbuf0_v,
  input  logic                    fetchbuf1_v,
  input  logic                    fetchbuf0_rfw,
  input  logic                    fetchbuf1_rfw,
  input  logic                    fetchbuf0_backbr,
  input  logic                    fetchbuf0_lk,
  input  regspec_t                Rt0,
  input  regspec_t                Rt1,
  input  que_ndx_t                tail0,
  input  que_ndx_t                tail1,
  input  logic     [QENTRIES-1:0] iq_v,
  input  logic     [QENTRIES-1:0] iq_rfw,
  input  regspec_t [QENTRIES-1:0] iq_tgt,
  input  logic                    commit0_v,
  input  logic                    commit1_v,
  input  regspec_t                commit0_tgt,
  input  regspec_t                commit1_tgt,
  input  logic     [4:0]          commit0_id,
  input  logic     [4:0]          commit1_id,
  output tag_t     [AREGS-1:0]    rf_source,
  output logic     [AREGS-1:0]    livetarget,
  output logic     [QENTRIES-1:0] iqentry_source
);

  tag_t     [AREGS-1:0] src_q;
  tag_t     [AREGS-1:0] src_d;
  tag_t     [AREGS-1:0] base;
  logic     [AREGS-1:0] surv_hit;
  logic     [AREGS-1:0] any_hit;
  que_ndx_t [AREGS-1:0] surv_idx;

  logic     en0, en1;
  regspec_t reg0, reg1;
  tag_t     tag0, tag1;

  for (genvar r = 0; r < AREGS; r++) begin : g_scan
    thor2024_youngest_producer #(
      .QENTRIES (QENTRIES),
      .REG      (regspec_t'(r))
    ) u_scan (
      .head0_i    (head0),
      .missid_i   (missid),
      .iq_v_i     (iq_v),
      .iq_rfw_i   (iq_rfw),
      .iq_tgt_i   (iq_tgt),
      .surv_hit_o (surv_hit[r]),
      .surv_idx_o (surv_idx[r]),
      .any_hit_o  (any_hit[r])
    );
  end

  // Starting point for this cycle: current table, or the rebuilt one on a miss.
  always_comb begin
    base = src_q;
    for (int r = 0; r < AREGS; r++) begin
      if (r == 0) begin
        base[r] = TAG_NONE;
      end else if (branchmiss) begin
        base[r] = surv_hit[r] ? qtag(surv_idx[r]) : TAG_NONE;
      end
    end
  end

  // Enqueue decode: which slots write which register with which tag.
  always_comb begin
    en0  = 1'b0;
    en1  = 1'b0;
    reg0 = Rt0;
    reg1 = Rt1;
    tag0 = qtag(tail0);
    tag1 = qtag(tail1);
    if (!branchmiss) begin
      case ({fetchbuf0_v, fetchbuf1_v})
        2'b01: begin
          en1  = !iq_v[tail0] && fetchbuf1_rfw;
          tag1 = qtag(tail0);
        end
        2'b10: begin
          en0 = !iq_v[tail0] && fetchbuf0_rfw;
        end
        2'b11: begin
          if (fetchbuf0_backbr) begin
            // Slot 1 is dropped behind a taken back branch; only the link write counts.
            en0  = !iq_v[tail0] && fetchbuf0_lk;
            reg0 = regspec_t'(LR0);
          end else if (!iq_v[tail0]) begin
            if (!iq_v[tail1] && (SUPPORT_Q2 != 0)) begin
              if (Rt0 == Rt1) begin
                // Younger slot owns a shared target.
                en1 = fetchbuf1_rfw;
                en0 = !fetchbuf1_rfw && fetchbuf0_rfw;
              end else begin
                en0 = fetchbuf0_rfw;
                en1 = fetchbuf1_rfw;
              end
            end else begin
              en0 = fetchbuf0_rfw;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Commits clear matching tags; enqueue writes land last so they win.
  always_comb begin
    src_d = base;
    if (commit0_v && (base[commit0_tgt] == commit0_id)) begin
      src_d[commit0_tgt] = TAG_NONE;
    end
    if (commit1_v && (base[commit1_tgt] == commit1_id)) begin
      src_d[commit1_tgt] = TAG_NONE;
    end
    if (en0) begin
      src_d[reg0] = tag0;
    end
    if (en1) begin
      src_d[reg1] = tag1;
    end
    src_d[0] = TAG_NONE;
  end

  // Table state; reset empties every entry to "in register file".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q <= {AREGS{TAG_NONE}};
    end else begin
      src_q <= src_d;
    end
  end

  // A register is live if any surviving entry (all valid entries absent a miss) targets it.
  always_comb begin
    livetarget = '0;
    for (int r = 0; r < AREGS; r++) begin
      livetarget[r] = branchmiss ? surv_hit[r] : any_hit[r];
    end
  end

  // Entry i is the current producer of its own target register.
  always_comb begin
    iqentry_source = '0;
    for (int i = 0; i < QENTRIES; i++) begin
      iqentry_source[i] = iq_v[i] && (src_q[iq_tgt[i]] == qtag(que_ndx_t'(i)));
    end
  end

  assign rf_source = src_q;

endmodule

// File: tb/tb_thor2024_regfile_source.sv
// Directed bench for the Thor2024 register source-tag table.
module tb_thor2024_regfile_source;

  logic            clk = 1'b0;
  logic            rst;
  logic            branchmiss;
  logic [2:0]      missid, head0;
  logic            fetchbuf0_v, fetchbuf1_v, fetchbuf0_rfw, fetchbuf1_rfw;
  logic            fetchbuf0_backbr, fetchbuf0_lk;
  logic [5:0]      Rt0, Rt1;
  logic [2:0]      tail0, tail1;
  logic [7:0]      iq_v, iq_rfw;
  logic [7:0][5:0] iq_tgt;
  logic            commit0_v, commit1_v;
  logic [5:0]      commit0_tgt, commit1_tgt;
  logic [4:0]      commit0_id, commit1_id;
  logic [63:0][4:0] rf_source;
  logic [63:0]     livetarget;
  logic [7:0]      iqentry_source;

  int n_chk = 0;
  int n_bad = 0;

  thor2024_regfile_source dut (
    .clk              (clk),
    .rst              (rst),
    .branchmiss       (branchmiss),
    .missid           (missid),
    .head0            (head0),
    .fetchbuf0_v      (fetchbuf0_v),
    .fetchbuf1_v      (fetchbuf1_v),
    .fetchbuf0_rfw    (fetchbuf0_rfw),
    .fetchbuf1_rfw    (fetchbuf1_rfw),
    .fetchbuf0_backbr (fetchbuf0_backbr),
    .fetchbuf0_lk     (fetchbuf0_lk),
    .Rt0              (Rt0),
    .Rt1              (Rt1),
    .tail0            (tail0),
    .tail1            (tail1),
    .iq_v             (iq_v),
    .iq_rfw           (iq_rfw),
    .iq_tgt           (iq_tgt),
    .commit0_v        (commit0_v),
    .commit1_v        (commit1_v),
    .commit0_tgt      (commit0_tgt),
    .commit1_tgt      (commit1_tgt),
    .commit0_id       (commit0_id),
    .commit1_id       (commit1_id),
    .rf_source        (rf_source),
    .livetarget       (livetarget),
    .iqentry_source   (iqentry_source)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    branchmiss = 0; missid = 0; head0 = 0;
    fetchbuf0_v = 0; fetchbuf1_v = 0; fetchbuf0_rfw = 0; fetchbuf1_rfw = 0;
    fetchbuf0_backbr = 0; fetchbuf0_lk = 0;
    Rt0 = 0; Rt1 = 0; tail0 = 0; tail1 = 0;
    iq_v = 0; iq_rfw = 0; iq_tgt = '0;
    commit0_v = 0; commit1_v = 0; commit0_tgt = 0; commit1_tgt = 0;
    commit0_id = 0; commit1_id = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-slot enqueue of register rt at queue position t.
  task automatic enq0(input logic [5:0] rt, input logic [2:0] t);
    fetchbuf0_v = 1; fetchbuf0_rfw = 1; Rt0 = rt; tail0 = t;
  endtask

  // Entries 1, 3, 5 all target r9.
  task automatic load_r9_entries();
    iq_v = 8'b0010_1010; iq_rfw = 8'b0010_1010;
    iq_tgt = '0; iq_tgt[1] = 6'd9; iq_tgt[3] = 6'd9; iq_tgt[5] = 6'd9;
  endtask

  initial begin
    idle();
    rst = 0;
    tick(); tick();
    for (int r = 0; r < 64; r++) check($sformatf("reset_rf%0d", r), rf_source[r], 5'h1F);
    check("reset_live", livetarget, 64'h0);
    check("reset_iqsrc", iqentry_source, 8'h0);
    rst = 1;
    tick();

    // Dual enqueue to the same register: slot 1 wins.
    fetchbuf0_v = 1; fetchbuf1_v = 1; fetchbuf0_rfw = 1; fetchbuf1_rfw = 1;
    Rt0 = 5; Rt1 = 5; tail0 = 2; tail1 = 3;
    tick();
    idle();
    check("dual_same_rf5", rf_source[5], 5'd3);
    iq_v = 8'b0000_1100; iq_rfw = 8'b0000_1100; iq_tgt[2] = 5; iq_tgt[3] = 5;
    #1 check("dual_same_iqsrc", iqentry_source, 8'b0000_1000);
    idle();
    commit0_v = 1; commit0_tgt = 5; commit0_id = 2;
    tick();
    check("commit_stale_rf5", rf_source[5], 5'd3);
    commit0_id = 3;
    tick();
    idle();
    check("commit_match_rf5", rf_source[5], 5'h1F);

    // Dual enqueue, distinct targets.
    fetchbuf0_v = 1; fetchbuf1_v = 1; fetchbuf0_rfw = 1; fetchbuf1_rfw = 1;
    Rt0 = 10; Rt1 = 11; tail0 = 0; tail1 = 1;
    tick();
    check("dual_diff_rf10", rf_source[10], 5'd0);
    check("dual_diff_rf11", rf_source[11], 5'd1);

    // tail1 occupied: only slot 0 enqueues.
    iq_v = 8'b0000_0010; Rt0 = 13; Rt1 = 14; tail0 = 2; tail1 = 1;
    tick();
    check("tail1_busy_rf13", rf_source[13], 5'd2);
    check("tail1_busy_rf14", rf_source[14], 5'h1F);

    // Same target, slot 1 not writing: slot 0 claims it.
    iq_v = 0; Rt0 = 15; Rt1 = 15; tail0 = 4; tail1 = 5; fetchbuf1_rfw = 0;
    tick();
    idle();
    check("same_tgt_s0_rf15", rf_source[15], 5'd4);

    // Linking back branch.
    fetchbuf0_v = 1; fetchbuf1_v = 1; fetchbuf0_backbr = 1; fetchbuf0_lk = 1;
    fetchbuf1_rfw = 1; Rt0 = 3; Rt1 = 7; tail0 = 4; tail1 = 5;
    tick();
    idle();
    check("backbr_rf56", rf_source[56], 5'd4);
    check("backbr_rf7", rf_source[7], 5'h1F);

    // r0 never takes a tag.
    enq0(6'd0, 3'd1);
    tick();
    idle();
    check("r0_fixed", rf_source[0], 5'h1F);

    // Branch-miss restore: head0=1, missid=4, survivors 1..4 -> youngest r9 producer is 3.
    enq0(6'd9, 3'd5);
    tick();
    idle();
    check("pre_miss_rf9", rf_source[9], 5'd5);
    load_r9_entries();
    head0 = 1; missid = 4; branchmiss = 1;
    enq0(6'd20, 3'd0);
    #1 check("miss_live9", livetarget[9], 1'b1);
    tick();
    branchmiss = 0; fetchbuf0_v = 0; fetchbuf0_rfw = 0;
    check("miss_rf9", rf_source[9], 5'd3);
    check("miss_enq_ignored_rf20", rf_source[20], 5'h1F);
    check("miss_rf56_cleared", rf_source[56], 5'h1F);
    check("miss_rf10_cleared", rf_source[10], 5'h1F);
    #1 check("miss_iqsrc", iqentry_source, 8'b0000_1000);
    check("miss_iqsrc5", iqentry_source[5], 1'b0);

    // Single survivor (missid==head0) that is not valid: nothing live, tag cleared.
    head0 = 4; missid = 4;
    #1 check("nomiss_live9", livetarget[9], 1'b1);
    branchmiss = 1;
    #1 check("single_surv_live9", livetarget[9], 1'b0);
    tick();
    check("single_surv_rf9", rf_source[9], 5'h1F);

    // Whole queue survives (missid = head0-1).
    head0 = 1; missid = 0;
    tick();
    check("whole_q_rf9", rf_source[9], 5'd5);

    // Wrap: entry 0 is younger than entry 7 when head0=7.
    iq_v = 8'b1000_0001; iq_rfw = 8'b1000_0001; iq_tgt = '0;
    iq_tgt[7] = 9; iq_tgt[0] = 9; head0 = 7; missid = 1;
    tick();
    check("wrap_rf9", rf_source[9], 5'd0);

    // Restore then commit the restored producer in the same cycle.
    load_r9_entries();
    head0 = 1; missid = 4;
    commit0_v = 1; commit0_tgt = 9; commit0_id = 3;
    tick();
    idle();
    check("miss_commit_rf9", rf_source[9], 5'h1F);

    // Enqueue beats commit on the same register.
    enq0(6'd12, 3'd6);
    tick();
    check("enq_rf12", rf_source[12], 5'd6);
    commit0_v = 1; commit0_tgt = 12; commit0_id = 6;
    tick();
    idle();
    check("enq_over_commit_rf12", rf_source[12], 5'd6);
    commit1_v = 1; commit1_tgt = 12; commit1_id = 6;
    tick();
    idle();
    check("commit1_rf12", rf_source[12], 5'h1F);

    // Asynchronous reset mid-cycle.
    enq0(6'd12, 3'd2);
    tick();
    idle();
    check("pre_areset_rf12", rf_source[12], 5'd2);
    rst = 0;
    #1 check("areset_rf12", rf_source[12], 5'h1F);
    rst = 1;
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/thor2024_regfile_source.md
# thor2024_regfile_source

Register source-tag table for the Thor2024 out-of-order core. It sits directly upstream of the register-valid tracker. For every architectural register it records which issue-queue entry will produce the register's next value. It supplies three outputs to the valid tracker and to operand-source lookup at enqueue: `rf_source`, `livetarget` and `iqentry_source`. The table updates at enqueue and at commit, and rebuilds itself from surviving queue entries on a branch miss.

## Interface
Parameters:
- AREGS, 64, number of architectural registers
- QENTRIES, 8, issue-queue depth
- LR0, 56, link register written by linking back-branches
- SUPPORT_Q2, 1, permits dual enqueue

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- branchmiss  in  1  mispredict restore request this cycle
- missid  in  3  queue index of the mispredicted branch
- head0  in  3  oldest queue entry
- fetchbuf0_v, fetchbuf1_v  in  1 each  fetch-buffer slot valid
- fetchbuf0_rfw, fetchbuf1_rfw  in  1 each  slot writes a register
- fetchbuf0_backbr  in  1  slot 0 is a predicted-taken back branch
- fetchbuf0_lk  in  1  slot 0 back branch links (writes LR0)
- Rt0, Rt1  in  6 each  target registers of slots 0 and 1
- tail0, tail1  in  3 each  enqueue positions
- iq_v  in  QENTRIES  per-entry valid, state before this edge
- iq_rfw  in  QENTRIES  per-entry writes a register
- iq_tgt  in  QENTRIES×6  per-entry target register
- commit0_v, commit1_v  in  1 each  commit slot valid
- commit0_tgt, commit1_tgt  in  6 each  committing target
- commit0_id, commit1_id  in  5 each  committing queue id
- rf_source  out  AREGS×5  producer tag per register; 5'h1F means no pending producer
- livetarget  out  AREGS  register targeted by a valid queue entry that survives the miss
- iqentry_source  out  QENTRIES  entry i is the current producer of iq_tgt[i]

## Operation
- Tag encoding: {2'b00, qidx} means pending producer qidx. 5'h1F means the register value is in the register file. rf_source[0] is always 5'h1F.
- Enqueue is ignored while branchmiss=1. Enqueue cases, keyed on {fetchbuf0_v, fetchbuf1_v}:
  - 00: no change.
  - 01: if !iq_v[tail0] and fetchbuf1_rfw, then rf_source[Rt1] ← tail0.
  - 10: if !iq_v[tail0] and fetchbuf0_rfw, then rf_source[Rt0] ← tail0.
  - 11, slot 0 is a back branch: if !iq_v[tail0] and fetchbuf0_lk, then rf_source[LR0] ← tail0. Slot 1 is not enqueued.
  - 11, otherwise, when !iq_v[tail0] && !iq_v[tail1] && SUPPORT_Q2:
    - Rt0==Rt1: slot 1 wins (rf_source ← tail1) if fetchbuf1_rfw. Otherwise slot 0 writes tail0 if fetchbuf0_rfw.
    - Rt0≠Rt1: each slot writes independently.
  - 11, only tail0 free: slot 0 only.
- Commit, per slot: if rf_source[tgt]==id, then rf_source[tgt] ← 5'h1F. An enqueue to the same register in the same cycle takes priority over commit.
- Branch-miss restore:
  - Survivors are the entries from head0 through missid inclusive, with wrap-around.
  - For each register r≠0, rf_source[r] ← the youngest survivor with iq_v && iq_rfw && iq_tgt==r. If there is none, rf_source[r] ← 5'h1F.
  - Commits in the same cycle then clear tags as above, using the post-restore value.
- livetarget[r] = OR over survivors of (iq_v && iq_rfw && iq_tgt==r). When branchmiss=0, every valid entry counts as a survivor. This output is combinational.
- iqentry_source[i] = iq_v[i] && rf_source[iq_tgt[i]]=={2'b00,i}. This output is combinational from registered state.

## Timing
- Reset: every rf_source entry is 5'h1F. livetarget and iqentry_source are then 0 given iq_v=0.
- Enqueue, commit and restore updates are visible on rf_source one cycle after the edge. There are no stalls and no handshake.
- Restore completes in a single cycle. A back-to-back branchmiss re-evaluates from the current queue state.
- Reset deassertion mid-operation: the table starts all 5'h1F. The queue is flushed by its own reset.
- missid==head0: only one survivor. missid==head0-1 mod QENTRIES: the whole queue survives.

## Structure
- The tag width, the 5'h1F "none" constant, que_ndx_t and regspec_t belong in Thor2024pkg.
- One sub-module, thor2024_youngest_producer. It is a combinational scan that returns the youngest survivor for one register, given head0 and missid, and is instantiated per register by a generate loop.

## Test plan
- Reset, then read all tags → rf_source all 5'h1F, livetarget 0.
- Dual enqueue with Rt0=Rt1=5, tail0=2, tail1=3, both rfw=1 → rf_source[5]=3. Then commit id 2 with target 5 → rf_source[5] stays 3. Then commit id 3 → rf_source[5]=5'h1F.
- Back branch with lk=1 at tail0=4, fetchbuf1_rfw=1 on Rt1=7 → rf_source[56]=4, rf_source[7] unchanged.
- Entries 1→r9, 3→r9, 5→r9, head0=1, branchmiss with missid=4 → rf_source[9]=3, livetarget[9]=1, iqentry_source[5]=0.
- Same setup with missid=0 → entries 1..7 and 0 all survive, so rf_source[9]=5. An entry at head0 wrapped from 7 to 0 resolves correctly.
- Enqueue to r12 at tail0=6 in the same cycle as a commit of id 6 (currently rf_source[12]=6) → rf_source[12]=6.
